nn_frame_feeder: RTL and testbench
==================================

NN_FRAME_FEEDER -- requirements
Module: nn_frame_feeder

Interface
REQ-001 SHALL have parameter WIDTH, default 22: signed fixed-point word width.
REQ-002 SHALL have parameter N_FEAT, default 16: features per frame sent to the network.
REQ-003 SHALL have parameter N_OUT, default 5: network output count.
REQ-004 SHALL have parameter TIMEOUT, default 1024: maximum cycles to wait for a network result.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset).
REQ-007 SHALL have port s_valid, input, 1 bit: feature stream beat valid.
REQ-008 SHALL have port s_ready, output, 1 bit: feature stream beat accepted when s_valid and s_ready are both 1.
REQ-009 SHALL have port s_data, input, WIDTH bits, signed: feature value.
REQ-010 SHALL have port s_last, input, 1 bit: marks the final beat of a frame.
REQ-011 SHALL have port nn_input_ready, output, 1 bit: one-cycle start pulse to the network.
REQ-012 SHALL have port nn_input_data, output, array [0:N_FEAT-1] of WIDTH bits, signed: frame presented to the network.
REQ-013 SHALL have port nn_output_ready, input, 1 bit: network result valid.
REQ-014 SHALL have port nn_output_data, input, array [0:N_OUT-1] of WIDTH bits, signed: network result.
REQ-015 SHALL have port result_valid, output, 1 bit: a captured result is held.
REQ-016 SHALL have port result_ready, input, 1 bit: consumer acknowledges the held result.
REQ-017 SHALL have port result_data, output, array [0:N_OUT-1] of WIDTH bits, signed: captured network outputs.
REQ-018 SHALL have port result_class, output, $clog2(N_OUT) bits: argmax index of result_data.
REQ-019 SHALL have port frame_err, output, 1 bit: one-cycle pulse when a malformed frame is discarded.
REQ-020 SHALL have port timeout_err, output, 1 bit: one-cycle pulse when a network wait times out.
REQ-021 SHALL have port frame_count, output, 16 bits: count of frames fired, wrapping.

Function
REQ-022 SHALL implement states FILL, FIRE, WAIT and RESULT.
REQ-023 SHALL, in FILL only, assert s_ready=1 and store each accepted beat at index beat_cnt, then increment beat_cnt.
REQ-024 SHALL treat an accepted beat with beat_cnt==N_FEAT-1 and s_last=1 as frame complete, going to FIRE on the next cycle.
REQ-025 SHALL, on an accepted beat where s_last disagrees with (beat_cnt==N_FEAT-1), pulse frame_err on the next cycle, discard the partial frame, reset beat_cnt to 0 and stay in FILL.
REQ-026 SHALL, in FIRE, hold nn_input_ready=1 for exactly one cycle, increment frame_count (wrapping at 0xFFFF to 0) and go to WAIT.
REQ-027 SHALL keep nn_input_data registered and stable from FIRE until the next FIRE; the FILL buffer is separate, so nn_input_data never changes mid-inference.
REQ-028 SHALL, in WAIT, count cycles from 0; on the first cycle nn_output_ready=1 it SHALL capture nn_output_data into result_data, capture the argmax into result_class, and go to RESULT.
REQ-029 SHALL compute argmax as a signed comparison, with the lowest index winning ties.
REQ-030 SHALL, if the WAIT count reaches TIMEOUT-1 with no nn_output_ready, pulse timeout_err, leave the result registers unchanged and go to FILL.
REQ-031 SHALL give nn_output_ready precedence over timeout when both occur on the same cycle.
REQ-032 SHALL ignore nn_output_ready in FILL, FIRE and RESULT.
REQ-033 SHALL hold result_valid=1 in RESULT until result_ready=1, then go to FILL on the next cycle.
REQ-034 SHALL hold result_data and result_class stable while result_valid=1.
REQ-035 SHALL meet these latencies: final beat accepted at cycle t gives nn_input_ready=1 at t+1; nn_output_ready at cycle u gives result_valid=1 at u+1.

Reset
REQ-036 SHALL, while reset=0 at a clock edge, set state to FILL, beat_cnt to 0, frame_count to 0, and drive s_ready, nn_input_ready, result_valid, frame_err and timeout_err to 0.
REQ-037 SHALL clear all nn_input_data, result_data and result_class entries to 0 on reset.
REQ-038 SHALL drive s_ready=1 on the first cycle after reset returns to 1.
REQ-039 SHALL, when reset is asserted mid-frame or mid-WAIT, abandon all in-flight state, and no error pulse SHALL be emitted.

Verification
REQ-040 SHALL cover a nominal frame: 16 beats of values 1..16 with s_last on beat 16 and nn_output_ready 10 cycles after the pulse, using outputs {3,-2,7,7,0} -> nn_input_ready pulses once, nn_input_data[0]=1 and [15]=16, result_class=2, frame_count=1.
REQ-041 SHALL cover a short frame: s_last on beat 5 -> frame_err pulses once, no nn_input_ready, and the next 16-beat frame fires normally.
REQ-042 SHALL cover a timeout: no nn_output_ready for 1024 cycles -> timeout_err pulses once, state returns to FILL, and result_valid stays 0.
REQ-043 SHALL cover backpressure: result_ready held at 0 for 50 cycles -> result_valid and result_data stay stable, s_ready=0, and FILL is entered one cycle after result_ready=1.
REQ-044 SHALL cover reset at beat 8 -> outputs return to reset values, and a fresh 16-beat frame fires with frame_count=1.
REQ-045 SHALL cover all-negative outputs {-5,-1,-9,-1,-3} -> result_class=1.

Source files
------------

// File: rtl/nn_frame_feeder.sv
// nn_frame_feeder
// Collects a frame of N_FEAT signed features from a valid/ready stream and
// fires it at a neural-network block. It then waits (bounded by TIMEOUT) for
// the network result, captures it with its argmax class, and holds it until
// a consumer acknowledges it.
//
// Ports
//   clk, reset        : rising-edge clock, synchronous active-low reset
//   s_valid/s_ready   : feature stream handshake, s_data value, s_last frame end
//   nn_input_ready    : one-cycle start pulse to the network
//   nn_input_data     : registered frame, stable from one FIRE to the next
//   nn_output_ready   : network result valid, nn_output_data its outputs
//   result_valid/ready: held-result handshake, result_data/result_class payload
//   frame_err         : one-cycle pulse, malformed frame discarded
//   timeout_err       : one-cycle pulse, network wait expired
//   frame_count       : frames fired, wraps at 16 bits
//   state_dbg         : current FSM state (FILL=0, FIRE=1, WAIT=2, RESULT=3)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. valid never depends on ready. While valid=1 and ready=0, the payload
// stays stable. This applies to s_* and to result_*.
module nn_frame_feeder #(
  parameter int WIDTH   = 22,
  parameter int N_FEAT  = 16,
  parameter int N_OUT   = 5,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic signed [WIDTH-1:0]    s_data,
  input  logic                       s_last,
  output logic                       nn_input_ready,
  output logic signed [WIDTH-1:0]    nn_input_data [0:N_FEAT-1],
  input  logic                       nn_output_ready,
  input  logic signed [WIDTH-1:0]    nn_output_data [0:N_OUT-1],
  output logic                       result_valid,
  input  logic                       result_ready,
  output logic signed [WIDTH-1:0]    result_data [0:N_OUT-1],
  output logic [$clog2(N_OUT)-1:0]   result_class,
  output logic                       frame_err,
  output logic                       timeout_err,
  output logic [15:0]                frame_count,
  output logic [1:0]                 state_dbg
);

  localparam int CW = $clog2(N_OUT);
  localparam int BW = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(N_FEAT - 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    FIRE   = 2'd1,
    WAIT   = 2'd2,
    RESULT = 2'd3
  } state_t;

  state_t                    state, state_next;
  logic                      in_reset;
  logic [BW-1:0]             beat_cnt;
  logic [TW-1:0]             wait_cnt;
  logic signed [WIDTH-1:0]   fill_buf [0:N_FEAT-1];
  logic                      accept;
  logic                      last_pos;
  logic [CW-1:0]             argmax_idx;
  logic signed [WIDTH-1:0]   argmax_val;

  assign state_dbg = state;

  // Next state and state-decoded outputs. in_reset keeps s_ready low on the
  // cycles that follow a reset edge. s_ready rises once the first edge with
  // reset=1 has passed.
  always_comb begin
    state_next     = state;
    s_ready        = (state == FILL) && !in_reset;
    nn_input_ready = (state == FIRE);
    result_valid   = (state == RESULT);
    accept         = s_valid && s_ready;
    last_pos       = (beat_cnt == LAST_BEAT);
    case (state)
      FILL:    if (accept && s_last && last_pos) state_next = FIRE;
      FIRE:    state_next = WAIT;
      WAIT: begin
        // A result on the final wait cycle beats the timeout.
        if (nn_output_ready)             state_next = RESULT;
        else if (wait_cnt == WAIT_LAST)  state_next = FILL;
      end
      RESULT:  if (result_ready) state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  // Signed argmax. The strict '>' keeps the lowest index on ties.
  always_comb begin
    argmax_idx = '0;
    argmax_val = nn_output_data[0];
    for (int i = 1; i < N_OUT; i++) begin
      if (nn_output_data[i] > argmax_val) begin
        argmax_val = nn_output_data[i];
        argmax_idx = CW'(i);
      end
    end
  end

  // Fill buffer is separate from nn_input_data, so a new frame can be
  // collected without disturbing the one the network is working on.
  always_ff @(posedge clk) begin
    if (state == FILL && accept) fill_buf[beat_cnt] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= FILL;
      in_reset     <= 1'b1;
      beat_cnt     <= '0;
      wait_cnt     <= '0;
      frame_count  <= '0;
      frame_err    <= 1'b0;
      timeout_err  <= 1'b0;
      result_class <= '0;
      for (int i = 0; i < N_FEAT; i++) nn_input_data[i] <= '0;
      for (int i = 0; i < N_OUT; i++)  result_data[i]   <= '0;
    end else begin
      state       <= state_next;
      in_reset    <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        FILL: begin
          if (accept) begin
            if (s_last != last_pos) begin
              // Early or missing s_last: drop the partial frame.
              frame_err <= 1'b1;
              beat_cnt  <= '0;
            end else if (last_pos) begin
              beat_cnt <= '0;
              // The final beat goes straight from s_data, because it is
              // being written into fill_buf on this same edge.
              for (int i = 0; i < N_FEAT; i++)
                nn_input_data[i] <= (i == N_FEAT - 1) ? s_data : fill_buf[i];
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        FIRE: begin
          frame_count <= frame_count + 16'd1;
          wait_cnt    <= '0;
        end
        WAIT: begin
          if (nn_output_ready) begin
            result_data  <= nn_output_data;
            result_class <= argmax_idx;
          end else if (wait_cnt == WAIT_LAST) begin
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_frame_feeder.sv
// Bench for nn_frame_feeder. The stimulus is directed. A behavioural model
// holds the expected frames, result and error-pulse cycles. One compare
// process checks the DUT against that model on every cycle. A few literal
// values pin the model.
module tb_nn_frame_feeder;
  localparam int WIDTH   = 22;
  localparam int N_FEAT  = 16;
  localparam int N_OUT   = 5;
  localparam int TIMEOUT = 1024;
  localparam int CW      = $clog2(N_OUT);

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic                    s_valid = 1'b0;
  logic                    s_ready;
  logic signed [WIDTH-1:0] s_data = '0;
  logic                    s_last = 1'b0;
  logic                    nn_input_ready;
  logic signed [WIDTH-1:0] nn_input_data [0:N_FEAT-1];
  logic                    nn_output_ready = 1'b0;
  logic signed [WIDTH-1:0] nn_output_data [0:N_OUT-1];
  logic                    result_valid;
  logic                    result_ready = 1'b0;
  logic signed [WIDTH-1:0] result_data [0:N_OUT-1];
  logic [CW-1:0]           result_class;
  logic                    frame_err;
  logic                    timeout_err;
  logic [15:0]             frame_count;
  logic [1:0]              state_dbg;

  nn_frame_feeder #(.WIDTH(WIDTH), .N_FEAT(N_FEAT), .N_OUT(N_OUT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .nn_input_ready(nn_input_ready), .nn_input_data(nn_input_data),
    .nn_output_ready(nn_output_ready), .nn_output_data(nn_output_data),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_data(result_data), .result_class(result_class),
    .frame_err(frame_err), .timeout_err(timeout_err),
    .frame_count(frame_count), .state_dbg(state_dbg)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Model state
  logic [N_FEAT*WIDTH-1:0] exp_q[$];
  int last_frame [N_FEAT];
  int exp_res [N_OUT];
  int exp_cls = 0;
  int exp_fire_cyc = -1, exp_ferr_cyc = -1, exp_to_cyc = -1, exp_res_cyc = -1;
  bit exp_busy = 1'b0, exp_rv = 1'b0, chk_en = 1'b0;
  int model_frames = 0;

  function automatic int argmax_model(input int v0, input int v1, input int v2, input int v3, input int v4);
    int v [N_OUT];
    int best;
    v = '{v0, v1, v2, v3, v4};
    best = 0;
    for (int i = 1; i < N_OUT; i++) if (v[i] > v[best]) best = i;
    return best;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    for (int i = 0; i < N_FEAT; i++) last_frame[i] = 0;
    for (int i = 0; i < N_OUT; i++) exp_res[i] = 0;
    exp_cls = 0;
    exp_fire_cyc = -1; exp_ferr_cyc = -1; exp_to_cyc = -1; exp_res_cyc = -1;
    exp_busy = 1'b0; exp_rv = 1'b0; model_frames = 0;
  endtask

  // Compare process: samples on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      bit fire_now;
      logic [N_FEAT*WIDTH-1:0] f;
      logic signed [WIDTH-1:0] tmp;
      fire_now = (cyc == exp_fire_cyc);
      chk("nn_input_ready", nn_input_ready, fire_now);
      chk("frame_err", frame_err, cyc == exp_ferr_cyc);
      chk("timeout_err", timeout_err, cyc == exp_to_cyc);
      chk("frame_count", frame_count, model_frames);
      if (cyc == exp_to_cyc) exp_busy = 1'b0;
      if (fire_now) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL fire_expected_frame @cyc %0d: got fire, expected no frame queued", cyc);
        end else begin
          f = exp_q.pop_front();
          for (int i = 0; i < N_FEAT; i++) begin
            tmp = f[i*WIDTH +: WIDTH];
            last_frame[i] = tmp;
          end
        end
        exp_busy = 1'b1;
        model_frames = (model_frames + 1) & 16'hFFFF;
      end
      for (int i = 0; i < N_FEAT; i++) chk("nn_input_data", nn_input_data[i], last_frame[i]);
      if (cyc == exp_res_cyc) exp_rv = 1'b1;
      chk("s_ready", s_ready, !exp_busy);
      chk("result_valid", result_valid, exp_rv);
      if (exp_rv) begin
        for (int i = 0; i < N_OUT; i++) chk("result_data", result_data[i], exp_res[i]);
        chk("result_class", result_class, exp_cls);
        if (result_ready) begin
          exp_rv = 1'b0;
          exp_busy = 1'b0;
        end
      end
    end
  end

  // Driver tasks: all called at #1 after a rising edge
  task automatic send_beat(input int d, input bit l, output int acc_cyc);
    int budget;
    budget = 200;
    s_valid = 1'b1; s_data = WIDTH'(d); s_last = l;
    while (!s_ready && budget > 0) begin @(posedge clk); #1; budget--; end
    if (!s_ready) begin
      vectors++; miscompares++;
      $display("FAIL s_ready_wait @cyc %0d: got s_ready 0, expected 1 within 200 cycles", cyc);
    end
    acc_cyc = cyc;
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_frame(input int n, input int base, input int last_at);
    int acc;
    logic [N_FEAT*WIDTH-1:0] f;
    f = '0;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      if (i < N_FEAT) f[i*WIDTH +: WIDTH] = WIDTH'(base + i);
      send_beat(base + i, i == last_at, acc);
    end
    if (n == N_FEAT && last_at == N_FEAT - 1) begin
      exp_q.push_back(f);
      exp_fire_cyc = acc + 1;
    end else begin
      exp_ferr_cyc = acc + 1;
    end
  endtask

  task automatic wait_fire(output int p);
    int budget;
    budget = 100;
    while (!nn_input_ready && budget > 0) begin @(posedge clk); #1; budget--; end
    if (!nn_input_ready) begin
      vectors++; miscompares++;
      $display("FAIL fire_wait @cyc %0d: got nn_input_ready 0, expected 1 within 100 cycles", cyc);
    end
    p = cyc;
  endtask

  task automatic respond(input int delay, input int v0, input int v1, input int v2, input int v3, input int v4);
    repeat (delay) begin @(posedge clk); #1; end
    nn_output_data[0] = WIDTH'(v0); nn_output_data[1] = WIDTH'(v1);
    nn_output_data[2] = WIDTH'(v2); nn_output_data[3] = WIDTH'(v3);
    nn_output_data[4] = WIDTH'(v4);
    exp_res = '{v0, v1, v2, v3, v4};
    exp_cls = argmax_model(v0, v1, v2, v3, v4);
    exp_res_cyc = cyc + 1;
    nn_output_ready = 1'b1;
    @(posedge clk); #1;
    nn_output_ready = 1'b0;
  endtask

  task automatic consume(input string nm, input int lit_cls);
    int budget;
    budget = 2000;
    while (!result_valid && budget > 0) begin @(posedge clk); #1; budget--; end
    chk({nm, "_result_valid"}, result_valid, 1);
    chk({nm, "_class"}, result_class, lit_cls);
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    chk({nm, "_fill_after_ack"}, s_ready, 1);
  endtask

  task automatic check_reset_values(input string nm);
    chk({nm, "_s_ready"}, s_ready, 0);
    chk({nm, "_nn_input_ready"}, nn_input_ready, 0);
    chk({nm, "_result_valid"}, result_valid, 0);
    chk({nm, "_frame_err"}, frame_err, 0);
    chk({nm, "_timeout_err"}, timeout_err, 0);
    chk({nm, "_frame_count"}, frame_count, 0);
    chk({nm, "_result_class"}, result_class, 0);
    for (int i = 0; i < N_FEAT; i++) chk({nm, "_nn_input_data"}, nn_input_data[i], 0);
    for (int i = 0; i < N_OUT; i++)  chk({nm, "_result_data"}, result_data[i], 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 1 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int dummy;
    for (int i = 0; i < N_OUT; i++) nn_output_data[i] = '0;
    model_clear();

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    chk("first_cycle_s_ready", s_ready, 1);

    // Nominal frame 1..16, result 10 cycles after the pulse
    send_frame(16, 1, 15);
    wait_fire(p);
    chk("nominal_in0", nn_input_data[0], 1);
    chk("nominal_in15", nn_input_data[15], 16);
    respond(10, 3, -2, 7, 7, 0);
    chk("nominal_latency", result_valid, 1);
    chk("nominal_frame_count", frame_count, 1);
    consume("nominal", 2);

    // nn_output_ready in FILL must be ignored
    nn_output_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    nn_output_ready = 1'b0;
    chk("ignore_fill_result_valid", result_valid, 0);

    // Short frame, then a normal one
    send_frame(5, 50, 4);
    @(posedge clk); #1;
    chk("short_no_fire", nn_input_ready, 0);
    send_frame(16, 100, 15);
    wait_fire(p);
    respond(4, 10, 20, 30, 40, 50);
    consume("after_short", 4);
    chk("after_short_frame_count", frame_count, 2);

    // Timeout: no network result
    send_frame(16, -16, 15);
    wait_fire(p);
    exp_to_cyc = p + TIMEOUT + 1;
    repeat (TIMEOUT + 3) begin @(posedge clk); #1; end
    chk("timeout_back_in_fill", s_ready, 1);
    chk("timeout_result_kept0", result_data[0], 10);
    chk("timeout_result_kept4", result_data[4], 50);

    // Backpressure: result held for 50 cycles
    send_frame(16, 200, 15);
    wait_fire(p);
    respond(3, -7, 12, 12, 3, 12);
    repeat (50) begin @(posedge clk); #1; end
    chk("backpressure_s_ready", s_ready, 0);
    consume("backpressure", 1);

    // All-negative outputs
    send_frame(16, 300, 15);
    wait_fire(p);
    respond(1, -5, -1, -9, -1, -3);
    consume("all_negative", 1);

    // Reset after beat 8
    for (int i = 0; i < 8; i++) send_beat(400 + i, 1'b0, dummy);
    chk_en = 1'b0;
    reset = 1'b0;
    model_clear();
    repeat (2) begin @(posedge clk); #1; end
    check_reset_values("midreset");
    reset = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    chk("midreset_first_s_ready", s_ready, 1);
    send_frame(16, 500, 15);
    wait_fire(p);
    chk("midreset_in0", nn_input_data[0], 500);
    respond(2, 1, 1, 1, 1, 1);
    chk("midreset_frame_count", frame_count, 1);
    consume("midreset", 0);

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
